alu_issue_ctrl: RTL and testbench

Command-side front end for the 8-bit ALU. It accepts operation commands over a valid/ready handshake and reads both operands from an internal 8×8 register file. It drives the ALU operand and opcode inputs, captures the ALU result and carry, writes the result back, and returns a response over a second valid/ready handshake. It sits between the instruction source and the combinational ALU and owns all sequencing around it.

---
 rtl/alu_issue_ctrl.sv | 161 ++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// Issue/capture/writeback sequencer in front of the combinational 8-bit ALU.
// Optional issued-op counter (op_count) is built when ALU_ISSUE_PERF_CNT_EN is defined.
module alu_issue_ctrl #(
  parameter int DATA_W = 8,
  parameter int REG_AW = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_valid,
  input  logic [REG_AW-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [REG_AW-1:0] cmd_srca,
  input  logic [REG_AW-1:0] cmd_srcb,
  input  logic [REG_AW-1:0] cmd_dst,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_operation,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_carry,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_carry,
  output logic              rsp_err
`ifdef ALU_ISSUE_PERF_CNT_EN
  ,
  output logic [15:0]       op_count
`endif
);

  localparam int NREGS = 2 ** REG_AW;

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

  state_t              state_q;
  logic [2:0]          op_q;
  logic [REG_AW-1:0]   srca_q, srcb_q, dst_q;
  logic [DATA_W-1:0]   alu_a_q, alu_b_q;
  logic [2:0]          alu_op_q;
  logic                rsp_valid_q, rsp_carry_q, rsp_err_q;
  logic [DATA_W-1:0]   rsp_data_q;

  logic                wr_en_d;
  logic [REG_AW-1:0]   wr_addr_d;
  logic [DATA_W-1:0]   wr_data_d;
  logic [NREGS-1:0][DATA_W-1:0] regs_rd;

  assign cmd_ready = (state_q == IDLE) && !load_valid;

  // Single register-file write port: preload in IDLE, ALU writeback in CAPTURE.
  always_comb begin
    wr_en_d   = 1'b0;
    wr_addr_d = load_addr;
    wr_data_d = load_data;
    if (state_q == IDLE && load_valid) begin
      wr_en_d = 1'b1;
    end else if (state_q == CAPTURE) begin
      wr_en_d   = 1'b1;
      wr_addr_d = dst_q;
      wr_data_d = alu_out;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_regs
      logic [DATA_W-1:0] reg_q;
      always_ff @(posedge clk) begin
        if (rst) begin
          reg_q <= '0;
        end else if (wr_en_d && wr_addr_d == REG_AW'(gi)) begin
          reg_q <= wr_data_d;
        end
      end
      assign regs_rd[gi] = reg_q;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      op_q        <= '0;
      srca_q      <= '0;
      srcb_q      <= '0;
      dst_q       <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_carry_q <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_valid && !load_valid) begin
            op_q   <= cmd_op;
            srca_q <= cmd_srca;
            srcb_q <= cmd_srcb;
            dst_q  <= cmd_dst;
            if (cmd_op <= 3'd4) begin
              state_q <= ISSUE;
            end else begin
              state_q     <= RESP;
              rsp_err_q   <= 1'b1;
              rsp_data_q  <= '0;
              rsp_carry_q <= 1'b0;
            end
          end
        end
        ISSUE: begin
          alu_a_q  <= regs_rd[srca_q];
          alu_b_q  <= regs_rd[srcb_q];
          alu_op_q <= op_q;
          state_q  <= CAPTURE;
        end
        CAPTURE: begin
          rsp_data_q  <= alu_out;
          rsp_carry_q <= alu_carry;
          rsp_err_q   <= 1'b0;
          rsp_valid_q <= 1'b1;
          state_q     <= RESP;
        end
        RESP: begin
          // Illegal ops enter RESP with valid still low; it rises one cycle later.
          if (!rsp_valid_q) begin
            rsp_valid_q <= 1'b1;
          end else if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef ALU_ISSUE_PERF_CNT_EN
  logic [15:0] op_count_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      op_count_q <= '0;
    end else if (state_q == CAPTURE) begin
      op_count_q <= op_count_q + 16'd1;
    end
  end
  assign op_count = op_count_q;
`endif

  assign alu_a         = alu_a_q;
  assign alu_b         = alu_b_q;
  assign alu_operation = alu_op_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_data      = rsp_data_q;
  assign rsp_carry     = rsp_carry_q;
  assign rsp_err       = rsp_err_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural ALU and a response scoreboard.
module tb_alu_issue_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load_valid = 1'b0;
  logic [2:0] load_addr = '0;
  logic [7:0] load_data = '0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [2:0] cmd_op = '0, cmd_srca = '0, cmd_srcb = '0, cmd_dst = '0;
  logic [7:0] alu_a, alu_b, alu_out;
  logic [2:0] alu_operation;
  logic       alu_carry;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [7:0] rsp_data;
  logic       rsp_carry, rsp_err;
`ifdef ALU_ISSUE_PERF_CNT_EN
  logic [15:0] op_count;
`endif

  always #5 clk = ~clk;

  alu_issue_ctrl dut (
    .clk(clk), .rst(rst),
    .load_valid(load_valid), .load_addr(load_addr), .load_data(load_data),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_srca(cmd_srca), .cmd_srcb(cmd_srcb), .cmd_dst(cmd_dst),
    .alu_a(alu_a), .alu_b(alu_b), .alu_operation(alu_operation),
    .alu_out(alu_out), .alu_carry(alu_carry),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_carry(rsp_carry), .rsp_err(rsp_err)
`ifdef ALU_ISSUE_PERF_CNT_EN
    , .op_count(op_count)
`endif
  );

  // Reference ALU: add carry-out, sub borrow-out, logic ops carry 0.
  function automatic logic [8:0] alu_ref(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'd0:    return {1'b0, a} + {1'b0, b};
      3'd1:    return {1'b0, a} - {1'b0, b};
      3'd2:    return {1'b0, a ^ b};
      3'd3:    return {1'b0, a | b};
      3'd4:    return {1'b0, a & b};
      default: return 9'd0;
    endcase
  endfunction

  logic [8:0] alu_res;
  always_comb alu_res = alu_ref(alu_operation, alu_a, alu_b);
  assign alu_out   = alu_res[7:0];
  assign alu_carry = alu_res[8];

  typedef struct packed {logic [7:0] data; logic carry; logic err;} rsp_t;
  rsp_t       sb_q[$];
  logic [7:0] model_regs [8];
  int         total = 0, passed = 0, last_wait = 0, exp_ops = 0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [2:0] a, input logic [7:0] d);
    load_valid = 1'b1; load_addr = a; load_data = d;
    tick();
    load_valid = 1'b0;
    model_regs[a] = d;
  endtask

  task automatic wait_rsp(input string tag);
    rsp_t e;
    int n = 0;
    while (!rsp_valid && n < 10) begin
      tick();
      n++;
    end
    check({tag, "_valid"}, 16'(rsp_valid), 16'd1);
    e = (sb_q.size() != 0) ? sb_q.pop_front() : '0;
    check({tag, "_data"}, 16'(rsp_data), 16'(e.data));
    check({tag, "_carry"}, 16'(rsp_carry), 16'(e.carry));
    check({tag, "_err"}, 16'(rsp_err), 16'(e.err));
    $display("rsp %s: data=0x%02h carry=%0d err=%0d", tag, rsp_data, rsp_carry, rsp_err);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check({tag, "_ready_after"}, 16'(cmd_ready), 16'd1);
  endtask

  task automatic issue(input logic [2:0] op, input logic [2:0] sa, input logic [2:0] sb,
                       input logic [2:0] d, input bit do_wait);
    logic [8:0] r;
    logic [7:0] av, bv;
    logic [2:0] prev_op;
    bit         legal;
    legal = (op <= 3'd4);
    av = model_regs[sa];
    bv = model_regs[sb];
    if (legal) begin
      r = alu_ref(op, av, bv);
      sb_q.push_back('{data: r[7:0], carry: r[8], err: 1'b0});
      model_regs[d] = r[7:0];
      exp_ops++;
    end else begin
      sb_q.push_back('{data: 8'h00, carry: 1'b0, err: 1'b1});
    end
    prev_op = alu_operation;
    cmd_valid = 1'b1; cmd_op = op; cmd_srca = sa; cmd_srcb = sb; cmd_dst = d;
    #1;
    last_wait = 0;
    while (!cmd_ready && last_wait < 10) begin
      tick();
      last_wait++;
    end
    tick();
    cmd_valid = 1'b0;
    check("accept_rsp_valid", 16'(rsp_valid), 16'd0);
    check("busy_cmd_ready", 16'(cmd_ready), 16'd0);
    tick();
    if (legal) begin
      check("issue_alu_a", 16'(alu_a), 16'(av));
      check("issue_alu_b", 16'(alu_b), 16'(bv));
      check("issue_alu_op", 16'(alu_operation), 16'(op));
      check("lat1_rsp_valid", 16'(rsp_valid), 16'd0);
      tick();
      check("lat2_rsp_valid", 16'(rsp_valid), 16'd1);
    end else begin
      check("illegal_lat1_valid", 16'(rsp_valid), 16'd1);
      check("illegal_alu_op_held", 16'(alu_operation), 16'(prev_op));
    end
    $display("cmd op=%0d srca=%0d srcb=%0d dst=%0d waited=%0d", op, sa, sb, d, last_wait);
    if (do_wait) wait_rsp("rsp");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 8; i++) model_regs[i] = 8'h00;
    tick(); tick();
    rst = 1'b0;
    check("reset_rsp_valid", 16'(rsp_valid), 16'd0);
    check("reset_cmd_ready", 16'(cmd_ready), 16'd1);
    check("reset_alu_a", 16'(alu_a), 16'd0);
    check("reset_alu_b", 16'(alu_b), 16'd0);
    check("reset_alu_op", 16'(alu_operation), 16'd0);
    check("reset_rsp_data", 16'(rsp_data), 16'd0);
    check("reset_rsp_err", 16'(rsp_err), 16'd0);
`ifdef ALU_ISSUE_PERF_CNT_EN
    check("reset_op_count", op_count, 16'd0);
`endif

    // add r1+r2 -> r3 = 0x10, then read r3 back through an OR
    load(3'd1, 8'h0F);
    load(3'd2, 8'h01);
    issue(3'd0, 3'd1, 3'd2, 3'd3, 1'b1);
    issue(3'd3, 3'd3, 3'd3, 3'd5, 1'b1);
    check("r3_readback", 16'(model_regs[5]), 16'h10);

    // sub with dst aliasing srca, then AND r1,r1
    load(3'd1, 8'h05);
    load(3'd2, 8'h07);
    issue(3'd1, 3'd1, 3'd2, 3'd1, 1'b1);
    issue(3'd4, 3'd1, 3'd1, 3'd4, 1'b1);

    // illegal opcode, then confirm r1 survived
    issue(3'd6, 3'd1, 3'd2, 3'd1, 1'b1);
    issue(3'd3, 3'd1, 3'd1, 3'd6, 1'b1);

    // back-pressure: rsp_ready held low for 5 cycles
    issue(3'd0, 3'd4, 3'd3, 3'd7, 1'b0);
    for (int i = 0; i < 5; i++) begin
      check("hold_rsp_valid", 16'(rsp_valid), 16'd1);
      check("hold_rsp_data", 16'(rsp_data), 16'(sb_q[0].data));
      check("hold_cmd_ready", 16'(cmd_ready), 16'd0);
      tick();
    end
    wait_rsp("held");
    issue(3'd2, 3'd7, 3'd1, 3'd0, 1'b1);
    check("post_hold_wait", 16'(last_wait), 16'd0);

    // load and command together: load wins, command accepted next cycle
    load_valid = 1'b1; load_addr = 3'd0; load_data = 8'h33;
    cmd_valid = 1'b1; cmd_op = 3'd0; cmd_srca = 3'd0; cmd_srcb = 3'd0; cmd_dst = 3'd2;
    #1;
    check("load_cmd_ready", 16'(cmd_ready), 16'd0);
    tick();
    load_valid = 1'b0;
    model_regs[0] = 8'h33;
    issue(3'd0, 3'd0, 3'd0, 3'd2, 1'b1);
    check("load_then_cmd_wait", 16'(last_wait), 16'd0);
`ifdef ALU_ISSUE_PERF_CNT_EN
    check("op_count_running", op_count, 16'(exp_ops));
`endif

    // reset asserted while in CAPTURE
    load(3'd1, 8'h21);
    cmd_valid = 1'b1; cmd_op = 3'd0; cmd_srca = 3'd1; cmd_srcb = 3'd1; cmd_dst = 3'd0;
    #1;
    tick();
    cmd_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) model_regs[i] = 8'h00;
    exp_ops = 0;
    $display("reset during capture");
    check("rst_rsp_valid", 16'(rsp_valid), 16'd0);
    check("rst_cmd_ready", 16'(cmd_ready), 16'd1);
    check("rst_alu_a", 16'(alu_a), 16'd0);
    check("rst_alu_op", 16'(alu_operation), 16'd0);
    check("rst_rsp_data", 16'(rsp_data), 16'd0);
`ifdef ALU_ISSUE_PERF_CNT_EN
    check("rst_op_count", op_count, 16'd0);
`endif
    load(3'd1, 8'h40);
    issue(3'd3, 3'd0, 3'd1, 3'd2, 1'b1);
    issue(3'd0, 3'd2, 3'd2, 3'd3, 1'b1);
    issue(3'd1, 3'd3, 3'd2, 3'd4, 1'b1);
`ifdef ALU_ISSUE_PERF_CNT_EN
    check("op_count_three", op_count, 16'd3);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
